inst_sram_responder: RTL and testbench

//  Responder side of the instruction SRAM interface: serves en/wen/addr/wdata requests from the fetch stage.

---
 rtl/inst_sram_responder_pkg.sv | 35 +++
 rtl/inst_sram_responder_byte_bank.sv | 45 ++++
 rtl/inst_sram_responder.sv | 175 +++++++++++++++++
 tb/tb_inst_sram_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_responder_pkg.sv
// ----------------------------------------------------------------------------
// inst_sram_responder_pkg
// Shared constants, types and helpers for the instruction SRAM responder.
//   INST_SRAM_BASE_PHYS   default physical byte address of word 0
//   INST_SRAM_DEPTH_LOG2  default log2 of the word count
//   LANE_W                stored bits per byte lane (8, or 9 with parity)
//   acc_kind_t            classification of the request seen this cycle
//   fold_addr()           kseg0/kseg1 virtual -> physical fold
// Optional feature macro: INST_SRAM_PARITY_EN (adds one even-parity bit per lane).
// ----------------------------------------------------------------------------
package inst_sram_responder_pkg;

    localparam logic [31:0] INST_SRAM_BASE_PHYS  = 32'h1fc0_0000;
    localparam int          INST_SRAM_DEPTH_LOG2 = 12;
    localparam int          NUM_LANES            = 4;

`ifdef INST_SRAM_PARITY_EN
    localparam int LANE_W = 9;
`else
    localparam int LANE_W = 8;
`endif

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_OOR   = 2'd3
    } acc_kind_t;

    // kseg0 (0x8...) and kseg1 (0xa...) both map onto the low 512 MiB.
    function automatic logic [31:0] fold_addr(input logic [28:0] vaddr_low);
        return {3'b000, vaddr_low};
    endfunction

endpackage

// File: rtl/inst_sram_responder_byte_bank.sv
// ----------------------------------------------------------------------------
// sram_byte_bank
// One byte lane of the instruction SRAM: a W-bit x DEPTH array with a single
// synchronous read-first port. The read register only updates on enabled
// accesses, so it holds the last response while idle.
// Ports:
//   clk    in  1   clock
//   reset  in  1   active-high; suppresses writes on a coinciding edge
//   en     in  1   access this cycle
//   we     in  1   write this lane (only when en)
//   addr   in  AW  word index
//   wdata  in  W   lane data (plus parity bit in the MSB when enabled)
//   rdata  out W   registered old contents of addr
// ----------------------------------------------------------------------------
module sram_byte_bank #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12,
    parameter int W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_q;

    // Array contents are never reset so this maps onto block RAM; reset
    // only gates the write enable.
    always_ff @(posedge clk) begin
        if (en) begin
            rdata_q <= mem_q[addr];
            if (we && !reset) begin
                mem_q[addr] <= wdata;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_sram_responder.sv
// ----------------------------------------------------------------------------
// inst_sram_responder
// Responder side of the instruction SRAM interface. Serves en/wen/addr/wdata
// requests with read data one cycle later, byte-lane writes (read-first),
// kseg0/kseg1 address folding, out-of-range flagging and a fetch counter.
// Optional feature macro: INST_SRAM_PARITY_EN -- per-lane even parity,
// checked on every in-range response.
// Ports:
//   clk              in  1   clock, rising edge
//   reset            in  1   asynchronous, active-high
//   inst_sram_en     in  1   request valid
//   inst_sram_wen    in  4   byte write enables, 0 = read
//   inst_sram_addr   in  32  virtual byte address
//   inst_sram_wdata  in  32  write data
//   inst_sram_rdata  out 32  response data
//   rsp_err          out 1   out-of-range flag aligned with rdata
//   err_sticky       out 1   any out-of-range request (or parity error) since reset
//   fetch_cnt        out 32  accepted in-range reads, wrapping
//   parity_err       out 1   parity mismatch aligned with rdata
// ----------------------------------------------------------------------------
module inst_sram_responder
    import inst_sram_responder_pkg::*;
#(
    parameter int          DEPTH     = 4096,
    parameter logic [31:0] BASE_PHYS = INST_SRAM_BASE_PHYS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        rsp_err,
    output logic        err_sticky,
    output logic [31:0] fetch_cnt,
    output logic        parity_err
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [31:0] SPAN = 32'(DEPTH) << 2;

    // ---------------- address fold and range check ----------------
    logic [31:0]   phys;
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          unused_addr_bits;

    assign phys     = fold_addr(inst_sram_addr[28:0]);
    assign off      = phys - BASE_PHYS;
    assign in_range = (off < SPAN);
    assign idx      = off[AW+1:2];
    assign unused_addr_bits = ^inst_sram_addr[31:29];

    acc_kind_t acc_kind;

    always_comb begin
        acc_kind = ACC_IDLE;
        if (inst_sram_en) begin
            if (!in_range) begin
                acc_kind = ACC_OOR;
            end else if (inst_sram_wen == 4'h0) begin
                acc_kind = ACC_READ;
            end else begin
                acc_kind = ACC_WRITE;
            end
        end
    end

    // ---------------- byte lanes ----------------
    logic             bank_en;
    logic [LANE_W-1:0] lane_rdata [NUM_LANES];
    logic [31:0]      rd_word;
    logic [NUM_LANES-1:0] lane_mismatch;

    // Out-of-range requests never touch the array.
    assign bank_en = (acc_kind == ACC_READ) || (acc_kind == ACC_WRITE);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : gen_lane
            logic [7:0]        lane_byte;
            logic [LANE_W-1:0] lane_wdata;

            assign lane_byte = inst_sram_wdata[8*gi +: 8];
`ifdef INST_SRAM_PARITY_EN
            // Even parity: stored 9-bit word always XORs to zero.
            assign lane_wdata          = {^lane_byte, lane_byte};
            assign lane_mismatch[gi]   = ^lane_rdata[gi];
`else
            assign lane_wdata          = lane_byte;
            assign lane_mismatch[gi]   = 1'b0;
`endif
            sram_byte_bank #(
                .DEPTH (DEPTH),
                .AW    (AW),
                .W     (LANE_W)
            ) u_bank (
                .clk   (clk),
                .reset (reset),
                .en    (bank_en),
                .we    (inst_sram_wen[gi]),
                .addr  (idx),
                .wdata (lane_wdata),
                .rdata (lane_rdata[gi])
            );

            assign rd_word[8*gi +: 8] = lane_rdata[gi][7:0];
        end
    endgenerate

    // ---------------- response registers ----------------
    // data_valid_q marks that the lane read registers hold an in-range
    // response; it masks rdata to zero after reset and after an
    // out-of-range request without needing a reset on the RAM outputs.
    logic        data_valid_q, data_valid_d;
    logic        rsp_err_q,    rsp_err_d;
    logic        err_sticky_q, err_sticky_d;
    logic [31:0] fetch_cnt_q,  fetch_cnt_d;
    logic        parity_hit;

`ifdef INST_SRAM_PARITY_EN
    assign parity_hit = data_valid_q && (|lane_mismatch);
`else
    assign parity_hit = 1'b0;
    logic unused_mismatch;
    assign unused_mismatch = |lane_mismatch;
`endif

    always_comb begin
        data_valid_d = data_valid_q;
        rsp_err_d    = rsp_err_q;
        err_sticky_d = err_sticky_q | parity_hit;
        fetch_cnt_d  = fetch_cnt_q;
        case (acc_kind)
            ACC_READ: begin
                data_valid_d = 1'b1;
                rsp_err_d    = 1'b0;
                fetch_cnt_d  = fetch_cnt_q + 32'd1;
            end
            ACC_WRITE: begin
                data_valid_d = 1'b1;
                rsp_err_d    = 1'b0;
            end
            ACC_OOR: begin
                data_valid_d = 1'b0;
                rsp_err_d    = 1'b1;
                err_sticky_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_valid_q <= 1'b0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            fetch_cnt_q  <= 32'd0;
        end else begin
            data_valid_q <= data_valid_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign inst_sram_rdata = data_valid_q ? rd_word : 32'd0;
    assign rsp_err         = rsp_err_q;
    // A parity hit is visible in the same cycle as the bad data.
    assign err_sticky      = err_sticky_q | parity_hit;
    assign fetch_cnt       = fetch_cnt_q;
    assign parity_err      = parity_hit;

endmodule

// File: tb/tb_inst_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_inst_sram_responder
// Directed bench for inst_sram_responder (DEPTH=16). A word-level model of
// the memory and output registers predicts every response; each transaction
// is compared against the model, and key points are also pinned to literal
// values. Build with INST_SRAM_PARITY_EN to exercise the parity path.
// ----------------------------------------------------------------------------
module tb_inst_sram_responder;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h1fc0_0000;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        err_sticky;
    logic [31:0] fetch_cnt;
    logic        parity_err;

    inst_sram_responder #(
        .DEPTH     (DEPTH),
        .BASE_PHYS (BASE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (en),
        .inst_sram_wen   (wen),
        .inst_sram_addr  (addr),
        .inst_sram_wdata (wdata),
        .inst_sram_rdata (rdata),
        .rsp_err         (rsp_err),
        .err_sticky      (err_sticky),
        .fetch_cnt       (fetch_cnt),
        .parity_err      (parity_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model state ----------------
    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    bit          m_badpar[DEPTH];
    logic [31:0] exp_rdata;
    bit          exp_known;
    logic        exp_err;
    logic        exp_sticky;
    logic [31:0] exp_cnt;
    logic        exp_par;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_rdata  = 32'd0;
        exp_known  = 1'b1;
        exp_err    = 1'b0;
        exp_sticky = 1'b0;
        exp_cnt    = 32'd0;
        exp_par    = 1'b0;
    endtask

    // Apply the spec rules for one clock edge with the current inputs.
    task automatic model_step(input logic m_en, input logic [3:0] m_wen,
                              input logic [31:0] m_addr, input logic [31:0] m_wdata);
        logic [31:0] phys;
        logic [31:0] off;
        int          idx;
        if (!m_en) return;
        phys = {3'b000, m_addr[28:0]};
        off  = phys - BASE;
        if (off < DEPTH * 4) begin
            idx       = int'(off / 4);
            exp_rdata = m_mem[idx];
            exp_known = m_known[idx];
            exp_err   = 1'b0;
            exp_par   = m_badpar[idx];
            if (exp_par) exp_sticky = 1'b1;
            if (m_wen == 4'h0) begin
                exp_cnt = exp_cnt + 32'd1;
            end else begin
                for (int i = 0; i < 4; i++)
                    if (m_wen[i]) m_mem[idx][8*i +: 8] = m_wdata[8*i +: 8];
                if (m_wen == 4'hf) m_known[idx] = 1'b1;
                if (m_wen[2]) m_badpar[idx] = 1'b0;
            end
        end else begin
            exp_rdata  = 32'd0;
            exp_known  = 1'b1;
            exp_err    = 1'b1;
            exp_sticky = 1'b1;
            exp_par    = 1'b0;
        end
    endtask

    task automatic compare_all();
        if (exp_known) chk("rdata", rdata, exp_rdata);
        chk("rsp_err",    32'(rsp_err),    32'(exp_err));
        chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
        chk("fetch_cnt",  fetch_cnt,       exp_cnt);
        chk("parity_err", 32'(parity_err), 32'(exp_par));
    endtask

    // One transaction: drive at negedge, model the edge, sample 1 time unit later.
    task automatic cycle(input logic c_en, input logic [3:0] c_wen,
                         input logic [31:0] c_addr, input logic [31:0] c_wdata);
        @(negedge clk);
        en    = c_en;
        wen   = c_wen;
        addr  = c_addr;
        wdata = c_wdata;
        @(posedge clk);
        model_step(c_en, c_wen, c_addr, c_wdata);
        #1;
        n_txn++;
        $display("txn %0d en=%b wen=%h addr=%h wdata=%h -> rdata=%h err=%b sticky=%b cnt=%0d par=%b",
                 n_txn, c_en, c_wen, c_addr, c_wdata, rdata, rsp_err, err_sticky, fetch_cnt, parity_err);
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]    = 32'd0;
            m_known[i]  = 1'b0;
            m_badpar[i] = 1'b0;
        end
        model_reset();
        reset = 1'b1;
        en    = 1'b0;
        wen   = 4'h0;
        addr  = 32'd0;
        wdata = 32'd0;
        #1;
        compare_all();
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Preload through the write port.
        cycle(1'b1, 4'hf, 32'hbfc0_0000, 32'h3c1d_0001);
        cycle(1'b1, 4'hf, 32'hbfc0_0010, 32'h1122_3344);
        cycle(1'b1, 4'hf, 32'hbfc0_0008, 32'hdead_beef);
        cycle(1'b1, 4'hf, 32'hbfc0_000c, 32'h0123_4567);
        cycle(1'b1, 4'hf, 32'hbfc0_003c, 32'hcafe_f00d);
        chk("preload_cnt", fetch_cnt, 32'd0);

        // 1: first read
        cycle(1'b1, 4'h0, 32'hbfc0_0000, 32'd0);
        chk("t1_rdata", rdata, 32'h3c1d_0001);
        chk("t1_cnt",   fetch_cnt, 32'd1);

        // 2: partial write is read-first, then read back merged word
        cycle(1'b1, 4'b0101, 32'hbfc0_0010, 32'haabb_ccdd);
        chk("t2_wr_rdata", rdata, 32'h1122_3344);
        cycle(1'b1, 4'h0, 32'hbfc0_0010, 32'd0);
        chk("t2_rd_rdata", rdata, 32'h11bb_33dd);

        // kseg0 alias of the last word (top boundary)
        cycle(1'b1, 4'h0, 32'h9fc0_003c, 32'd0);
        chk("kseg0_last", rdata, 32'hcafe_f00d);

        // 3: out of range just above and just below the window
        cycle(1'b1, 4'h0, 32'hbfc0_0040, 32'd0);
        chk("t3_rdata",  rdata, 32'd0);
        chk("t3_err",    32'(rsp_err), 32'd1);
        chk("t3_sticky", 32'(err_sticky), 32'd1);
        chk("t3_cnt",    fetch_cnt, 32'd3);
        cycle(1'b1, 4'hf, 32'hbfc0_0040, 32'h5555_5555);
        cycle(1'b1, 4'h0, 32'hbfbf_fffc, 32'd0);
        cycle(1'b1, 4'h0, 32'hbfc0_0000, 32'd0);
        chk("t3_back_err",    32'(rsp_err), 32'd0);
        chk("t3_back_sticky", 32'(err_sticky), 32'd1);
        chk("t3_oor_wr_drop", rdata, 32'h3c1d_0001);

        // 4: idle holds; wen/wdata ignored while en is low
        cycle(1'b1, 4'h0, 32'hbfc0_0008, 32'd0);
        cycle(1'b0, 4'hf, 32'hbfc0_0008, 32'h0000_0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 32'd0, 32'd0);
        chk("t4_hold", rdata, 32'hdead_beef);
        chk("t4_cnt",  fetch_cnt, 32'd5);
        cycle(1'b1, 4'h0, 32'hbfc0_0008, 32'd0);
        chk("t4_noidle_wr", rdata, 32'hdead_beef);

        // 5: counter wrap
        @(negedge clk);
        en = 1'b0;
        force dut.fetch_cnt_q = 32'hffff_ffff;
        #1;
        release dut.fetch_cnt_q;
        exp_cnt = 32'hffff_ffff;
        cycle(1'b1, 4'h0, 32'hbfc0_000c, 32'd0);
        chk("t5_wrap", fetch_cnt, 32'd0);

        // 5: asynchronous reset mid-stream, then an edge under reset writes nothing
        cycle(1'b1, 4'h0, 32'hbfc0_0008, 32'd0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("t5_rst_rdata",  rdata, 32'd0);
        chk("t5_rst_err",    32'(rsp_err), 32'd0);
        chk("t5_rst_sticky", 32'(err_sticky), 32'd0);
        chk("t5_rst_cnt",    fetch_cnt, 32'd0);
        chk("t5_rst_par",    32'(parity_err), 32'd0);
        @(negedge clk);
        en    = 1'b1;
        wen   = 4'hf;
        addr  = 32'hbfc0_0000;
        wdata = 32'h0000_0000;
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        wen   = 4'h0;
        cycle(1'b1, 4'h0, 32'hbfc0_0000, 32'd0);
        chk("t5_no_wr_in_rst", rdata, 32'h3c1d_0001);
        chk("t5_cnt_after",    fetch_cnt, 32'd1);

        // 6: parity
`ifdef INST_SRAM_PARITY_EN
        @(negedge clk);
        dut.gen_lane[2].u_bank.mem_q[3][8] = ~dut.gen_lane[2].u_bank.mem_q[3][8];
        m_badpar[3] = 1'b1;
        cycle(1'b1, 4'h0, 32'hbfc0_000c, 32'd0);
        chk("t6_par",    32'(parity_err), 32'd1);
        chk("t6_sticky", 32'(err_sticky), 32'd1);
`else
        cycle(1'b1, 4'h0, 32'hbfc0_000c, 32'd0);
        chk("t6_par_off", 32'(parity_err), 32'd0);
`endif
        cycle(1'b0, 4'h0, 32'd0, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
